// File: rtl/res_pack.sv
// -----------------------------------------------------------------------------
// res_pack
// Collects byte-wide results from the stimulus BFM / adder pair and packs them
// LSB-first into a PKT_BYTES-byte packet. The packet is presented with its
// length, a 16-bit byte checksum and a sequence number, so the testbench can
// hand it back to software in one transfer.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   reset_n_i    synchronous active-low reset
//   in_valid_i   input result valid
//   in_data_i    input result byte
//   in_ready_o   block can accept a result (high exactly while filling)
//   flush_i      close the current partial packet
//   pkt_valid_o  packet available
//   pkt_ready_i  consumer takes the packet
//   pkt_data_o   packet, byte k at bits [8k+7:8k], unused bytes read 0
//   pkt_len_o    number of valid bytes in the packet (1..256)
//   pkt_sum_o    sum of the packet bytes mod 2^16
//   pkt_seq_o    packet sequence number, wraps 0xFFFF -> 0
//   stall_cnt_o  (only with RES_PACK_STALL_CNT_EN) saturating count of cycles
//                a packet was held with pkt_ready_i low
//
// Optional feature macro: RES_PACK_STALL_CNT_EN
// -----------------------------------------------------------------------------
module res_pack #(
  parameter int DATA_W    = 8,
  parameter int PKT_BYTES = 256,
  parameter int PKT_W     = DATA_W * PKT_BYTES
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i,
  output logic [PKT_W-1:0]  pkt_data_o,
  output logic [8:0]        pkt_len_o,
  output logic [15:0]       pkt_sum_o,
  output logic [15:0]       pkt_seq_o
`ifdef RES_PACK_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  // PKT_W is derived; a mismatching override would misalign the byte lanes.
  // The 9-bit length and 16-bit sum also bound the other parameters.
  if (PKT_W != DATA_W * PKT_BYTES) begin : g_bad_pkt_w
    $error("res_pack: PKT_W must equal DATA_W*PKT_BYTES");
  end
  if (PKT_BYTES < 1 || PKT_BYTES > 256) begin : g_bad_pkt_bytes
    $error("res_pack: PKT_BYTES must be 1..256");
  end
  if (DATA_W > 16) begin : g_bad_data_w
    $error("res_pack: DATA_W must not exceed the checksum width");
  end

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [8:0]  cnt_reg, cnt_next;
  logic [15:0] sum_reg, sum_next;
  logic [15:0] seq_reg, seq_next;
  logic        in_ready_reg;
  logic        pkt_valid_reg;

  logic        accept;
  logic        last_byte;
  logic        close_pkt;
  logic        release_pkt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg     <= FILL;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      seq_reg       <= '0;
      in_ready_reg  <= 1'b0;
      pkt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sum_reg       <= sum_next;
      seq_reg       <= seq_next;
      // Handshake flags are registered copies of the next state, so they
      // track the state exactly except in the cycle right after reset, where
      // in_ready stays low until the first edge out of reset.
      in_ready_reg  <= (state_next == FILL);
      pkt_valid_reg <= (state_next == HOLD);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sum_next    = sum_reg;
    seq_next    = seq_reg;

    // in_ready is only high in FILL, so an accept never happens in HOLD.
    accept      = in_valid_i & in_ready_reg;
    last_byte   = accept && (cnt_reg == 9'(PKT_BYTES - 1));
    // A flush closes the packet only if it would not be empty; the byte
    // accepted in the same cycle counts. Flush together with the last byte
    // collapses into the ordinary full-packet case.
    close_pkt   = last_byte ||
                  (flush_i && (state_reg == FILL) && ((cnt_reg != 9'd0) || accept));
    release_pkt = pkt_valid_reg & pkt_ready_i;

    case (state_reg)
      FILL: begin
        if (accept) begin
          cnt_next = cnt_reg + 9'd1;
          sum_next = sum_reg + 16'(in_data_i);
        end
        if (close_pkt) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (release_pkt) begin
          state_next = FILL;
          cnt_next   = '0;
          sum_next   = '0;
          seq_next   = seq_reg + 16'd1;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet buffer: one register per byte lane. A lane is written only when the
  // fill counter points at it, and every lane is cleared when the packet is
  // released so that a later short packet reads zero in its unused lanes.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < PKT_BYTES; gi++) begin : g_byte
      logic [DATA_W-1:0] byte_reg;

      always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
          byte_reg <= '0;
        end else if (release_pkt) begin
          byte_reg <= '0;
        end else if (accept && (cnt_reg == 9'(gi))) begin
          byte_reg <= in_data_i;
        end
      end

      assign pkt_data_o[gi*DATA_W +: DATA_W] = byte_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional stall counter
  // ---------------------------------------------------------------------------
`ifdef RES_PACK_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == HOLD) && !pkt_ready_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all driven straight from registers. The fill counter doubles as
  // the length and the running sum as the checksum; both freeze in HOLD.
  // ---------------------------------------------------------------------------
  assign in_ready_o  = in_ready_reg;
  assign pkt_valid_o = pkt_valid_reg;
  assign pkt_len_o   = cnt_reg;
  assign pkt_sum_o   = sum_reg;
  assign pkt_seq_o   = seq_reg;

endmodule

// File: tb/tb_res_pack.sv
// -----------------------------------------------------------------------------
// tb_res_pack
// Directed testbench for res_pack: full packet, back-pressure, flush, empty
// flush, gapped input and reset in the middle of a packet. Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_res_pack;

  localparam int DATA_W    = 8;
  localparam int PKT_BYTES = 256;
  localparam int PKT_W     = DATA_W * PKT_BYTES;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              pkt_valid;
  logic              pkt_ready = 1'b0;
  logic [PKT_W-1:0]  pkt_data;
  logic [8:0]        pkt_len;
  logic [15:0]       pkt_sum;
  logic [15:0]       pkt_seq;
`ifdef RES_PACK_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int pkt_rises = 0;
  logic pv_prev = 1'b0;
  logic [PKT_W-1:0] exp_pkt;

  res_pack #(
    .DATA_W    (DATA_W),
    .PKT_BYTES (PKT_BYTES)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .pkt_valid_o (pkt_valid),
    .pkt_ready_i (pkt_ready),
    .pkt_data_o  (pkt_data),
    .pkt_len_o   (pkt_len),
    .pkt_sum_o   (pkt_sum),
    .pkt_seq_o   (pkt_seq)
`ifdef RES_PACK_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Count packets by rising edges of pkt_valid, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (pkt_valid && !pv_prev) pkt_rises++;
    pv_prev = pkt_valid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
      $display("check %s: got 0x%0h ok", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
  endtask

  initial begin
    int sent;
    int cycles;

    // ---------------- reset ----------------
    repeat (4) @(negedge clk);
    check("rst_in_ready",  in_ready, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_len",       pkt_len, 0);
    check("rst_sum",       pkt_sum, 0);
    check("rst_seq",       pkt_seq, 0);
    check("rst_data_zero", (pkt_data == '0), 1);
`ifdef RES_PACK_STALL_CNT_EN
    check("rst_stall",     stall_cnt, 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // ---------------- full packet 0x00..0xFF ----------------
    exp_pkt = '0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      exp_pkt[i*8 +: 8] = 8'(i);
      @(negedge clk);
      if (i == 254) check("full_not_early", pkt_valid, 0);
    end
    check("full_valid",    pkt_valid, 1);
    check("full_len",      pkt_len, 256);
    check("full_byte0",    pkt_data[7:0], 8'h00);
    check("full_byte255",  pkt_data[2047:2040], 8'hFF);
    check("full_sum",      pkt_sum, 16'h7F80);
    check("full_seq",      pkt_seq, 0);
    check("full_in_ready", in_ready, 0);
    check("full_data",     (pkt_data == exp_pkt), 1);

    // ---------------- back-pressure ----------------
    in_data = 8'hAA;
    repeat (10) @(negedge clk);
    check("bp_valid",    pkt_valid, 1);
    check("bp_data",     (pkt_data == exp_pkt), 1);
    check("bp_len",      pkt_len, 256);
    check("bp_sum",      pkt_sum, 16'h7F80);
    check("bp_in_ready", in_ready, 0);
`ifdef RES_PACK_STALL_CNT_EN
    check("bp_stall",    stall_cnt, 10);
`endif
    in_valid = 1'b0;
    consume();
    check("rel_in_ready", in_ready, 1);
    check("rel_seq",      pkt_seq, 1);
    check("rel_valid",    pkt_valid, 0);
    check("rel_pkts",     pkt_rises, 1);

    // ---------------- flush with third byte ----------------
    in_valid = 1'b1;
    in_data  = 8'h11;
    @(negedge clk);
    in_data  = 8'h22;
    @(negedge clk);
    in_data  = 8'h33;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("fl_valid", pkt_valid, 1);
    check("fl_len",   pkt_len, 3);
    check("fl_low",   pkt_data[23:0], 24'h332211);
    check("fl_upper_zero", (pkt_data[2047:24] == '0), 1);
    check("fl_sum",   pkt_sum, 16'h0066);
    check("fl_seq",   pkt_seq, 1);
    repeat (7) @(negedge clk);
    check("fl_hold_len", pkt_len, 3);
`ifdef RES_PACK_STALL_CNT_EN
    check("fl_stall", stall_cnt, 17);
`endif
    consume();
    check("fl_rel_seq", pkt_seq, 2);

    // ---------------- flush with nothing held ----------------
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("empty_fl_valid",    pkt_valid, 0);
    check("empty_fl_in_ready", in_ready, 1);
    check("empty_fl_pkts",     pkt_rises, 2);

    // ---------------- gapped input, 256 x 0x01 ----------------
    sent   = 0;
    cycles = 0;
    in_data = 8'h01;
    while (sent < 256 && cycles < 3000) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    check("gap_sent",  sent, 256);
    check("gap_valid", pkt_valid, 1);
    check("gap_len",   pkt_len, 256);
    check("gap_sum",   pkt_sum, 16'h0100);
    check("gap_pkts",  pkt_rises, 3);
    consume();
    repeat (2) @(negedge clk);
    check("gap_rel_seq",  pkt_seq, 3);
    check("gap_one_pkt",  pkt_rises, 3);

    // ---------------- reset mid-packet ----------------
    in_valid = 1'b1;
    in_data  = 8'h05;
    repeat (100) @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", pkt_valid, 0);
    check("mid_rst_sum",   pkt_sum, 0);
    check("mid_rst_len",   pkt_len, 0);
    check("mid_rst_seq",   pkt_seq, 0);
`ifdef RES_PACK_STALL_CNT_EN
    check("mid_rst_stall", stall_cnt, 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (256) @(negedge clk);
    in_valid = 1'b0;
    check("mid_valid", pkt_valid, 1);
    check("mid_len",   pkt_len, 256);
    check("mid_sum",   pkt_sum, 16'h0200);
    check("mid_seq",   pkt_seq, 0);
    check("mid_pkts",  pkt_rises, 4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
